// File: rtl/sdram_ahb_bridge_if.sv
// Bus bundle between the AHB-Lite fabric, the bridge and the SDRAM core.
// Slave modport is the bridge's view; master is the surrounding system.
interface sdram_ahb_bridge_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();
  localparam int WAW = AW - $clog2(DW / 8);

  logic              hsel;
  logic [AW-1:0]     haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DW-1:0]     hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DW-1:0]     hrdata;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WAW-1:0]    req_addr;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_be;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize,
    input  hwdata, hready,
    output hreadyout, hresp, hrdata,
    output req_valid, req_write, req_addr,
    output req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize,
    output hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sdram_ahb_bridge.sv
// AHB-Lite slave front-end for the SDRAM core: posted writes through a
// one-entry buffer, stalled reads, one outstanding core request.
module sdram_ahb_bridge #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input logic clk,
  input logic rst_n,
  sdram_ahb_bridge_if.slave bus
);
  localparam int BW  = DW / 8;
  localparam int BL  = $clog2(BW);
  localparam int BLI = (BL == 0) ? 1 : BL;
  localparam int WAW = AW - BL;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WDATA = 3'd1;
  localparam logic [2:0] S_WREQ  = 3'd2;
  localparam logic [2:0] S_RREQ  = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_RDONE = 3'd5;

  logic [2:0]     state, state_n;
  logic [AW-1:0]  cur_addr;
  logic           cur_write;
  logic [2:0]     cur_size;
  logic           pend, pend_n;
  logic [WAW-1:0] wb_addr;
  logic [DW-1:0]  wb_data;
  logic [BW-1:0]  wb_be;
  logic [DW-1:0]  rdata_q;

  logic accept, take, nxt_write, pend_now;

  function automatic logic [BW-1:0] be_of(
    input logic [2:0]    sz,
    input logic [AW-1:0] a
  );
    logic [BW-1:0] m;
    int n, off;
    m = '0;
    if (int'(sz) >= BL) begin
      m = '1;
    end else begin
      n   = 1 << sz;
      off = int'(a[BLI-1:0]) & ~(n - 1);
      for (int i = 0; i < BW; i++)
        m[i] = (i >= off) && (i < off + n);
    end
    return m;
  endfunction

  assign accept = bus.hsel & bus.htrans[1] & bus.hready;

  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      state == S_IDLE,
      state == S_WDATA,
      state == S_RDONE: take = accept;
      state == S_WREQ:  take = accept & ~pend;
      default:          take = 1'b0;
    endcase
  end

  // A transfer latched in the handshake cycle itself steers the exit.
  assign nxt_write = take ? bus.hwrite : cur_write;
  assign pend_now  = pend | (state == S_WREQ && take);

  always_comb begin
    state_n = state;
    pend_n  = pend;
    case (state)
      S_IDLE, S_RDONE: begin
        if (take) state_n = nxt_write ? S_WDATA : S_RREQ;
        else      state_n = S_IDLE;
      end
      S_WDATA: begin
        if (take) pend_n = 1'b1;
        state_n = S_WREQ;
      end
      S_WREQ: begin
        if (take) pend_n = 1'b1;
        if (bus.req_ready) begin
          pend_n = 1'b0;
          if (pend_now) state_n = nxt_write ? S_WDATA : S_RREQ;
          else          state_n = S_IDLE;
        end
      end
      S_RREQ:  if (bus.req_ready) state_n = S_RWAIT;
      S_RWAIT: if (bus.rsp_valid) state_n = S_RDONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      cur_write <= 1'b0;
      cur_size  <= '0;
      pend      <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      wb_be     <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      if (take) begin
        cur_addr  <= bus.haddr;
        cur_write <= bus.hwrite;
        cur_size  <= bus.hsize;
      end
      if (state == S_WDATA) begin
        wb_addr <= cur_addr[AW-1:BL];
        wb_data <= bus.hwdata;
        wb_be   <= be_of(cur_size, cur_addr);
      end
      if (state == S_RWAIT && bus.rsp_valid)
        rdata_q <= bus.rsp_rdata;
    end
  end

  always_comb begin
    bus.hreadyout = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    unique case (1'b1)
      state == S_IDLE,
      state == S_WDATA,
      state == S_RDONE: bus.hreadyout = 1'b1;
      state == S_WREQ: begin
        bus.hreadyout = ~pend;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = wb_addr;
        bus.req_wdata = wb_data;
        bus.req_be    = wb_be;
      end
      state == S_RREQ: begin
        bus.req_valid = 1'b1;
        bus.req_addr  = cur_addr[AW-1:BL];
        bus.req_be    = be_of(cur_size, cur_addr);
      end
      default: bus.hreadyout = 1'b0;
    endcase
  end

  assign bus.hresp  = 1'b0;
  assign bus.hrdata = rdata_q;

endmodule
